// File: rtl/alu_op_sequencer.sv
// Request/response front end for the 32-bit ALU: registers one operation onto the
// ALU inputs, waits SETTLE cycles, captures the result and returns it on a handshake.
module alu_op_sequencer #(
  parameter int BUS_WIDTH = 32,
  parameter int SETTLE    = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic [BUS_WIDTH-1:0] req_a,
  input  logic [BUS_WIDTH-1:0] req_b,
  input  logic [2:0]           req_md,
  input  logic                 req_cin,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [BUS_WIDTH-1:0] rsp_out,
  output logic                 rsp_cout,
  output logic                 rsp_zero,
  output logic [BUS_WIDTH-1:0] alu_a,
  output logic [BUS_WIDTH-1:0] alu_b,
  output logic [2:0]           alu_md,
  output logic                 alu_cin,
  output logic                 alu_en,
  input  logic [BUS_WIDTH-1:0] alu_out,
  input  logic                 alu_cout,
  input  logic                 alu_zero,
  output logic [15:0]          op_count
);

  generate
    if (SETTLE < 1 || SETTLE > 15) begin : g_bad_settle
      $error("alu_op_sequencer: SETTLE must be in 1..15");
    end
  endgenerate

  localparam logic [3:0] SETTLE_M1 = 4'(SETTLE - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRIVE = 2'd1,
    RESP  = 2'd2
  } state_t;

  state_t               state_reg, state_next;
  logic [3:0]           cnt_reg, cnt_next;
  logic [BUS_WIDTH-1:0] alu_a_reg, alu_a_next;
  logic [BUS_WIDTH-1:0] alu_b_reg, alu_b_next;
  logic [2:0]           alu_md_reg, alu_md_next;
  logic                 alu_cin_reg, alu_cin_next;
  logic                 alu_en_reg, alu_en_next;
  logic                 rsp_valid_reg, rsp_valid_next;
  logic [BUS_WIDTH-1:0] rsp_out_reg, rsp_out_next;
  logic                 rsp_cout_reg, rsp_cout_next;
  logic                 rsp_zero_reg, rsp_zero_next;
  logic [15:0]          op_count_reg, op_count_next;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= IDLE;
      cnt_reg       <= '0;
      alu_a_reg     <= '0;
      alu_b_reg     <= '0;
      alu_md_reg    <= '0;
      alu_cin_reg   <= 1'b0;
      alu_en_reg    <= 1'b1;
      rsp_valid_reg <= 1'b0;
      rsp_out_reg   <= '0;
      rsp_cout_reg  <= 1'b0;
      rsp_zero_reg  <= 1'b0;
      op_count_reg  <= '0;
    end else begin
      state_reg     <= state_next;
      cnt_reg       <= cnt_next;
      alu_a_reg     <= alu_a_next;
      alu_b_reg     <= alu_b_next;
      alu_md_reg    <= alu_md_next;
      alu_cin_reg   <= alu_cin_next;
      alu_en_reg    <= alu_en_next;
      rsp_valid_reg <= rsp_valid_next;
      rsp_out_reg   <= rsp_out_next;
      rsp_cout_reg  <= rsp_cout_next;
      rsp_zero_reg  <= rsp_zero_next;
      op_count_reg  <= op_count_next;
    end
  end

  always_comb begin
    state_next     = state_reg;
    cnt_next       = cnt_reg;
    alu_a_next     = alu_a_reg;
    alu_b_next     = alu_b_reg;
    alu_md_next    = alu_md_reg;
    alu_cin_next   = alu_cin_reg;
    alu_en_next    = alu_en_reg;
    rsp_valid_next = rsp_valid_reg;
    rsp_out_next   = rsp_out_reg;
    rsp_cout_next  = rsp_cout_reg;
    rsp_zero_next  = rsp_zero_reg;
    op_count_next  = op_count_reg;

    case (state_reg)
      IDLE: begin
        if (req_valid) begin
          alu_a_next   = req_a;
          alu_b_next   = req_b;
          alu_md_next  = req_md;
          alu_cin_next = req_cin;
          alu_en_next  = 1'b0;
          cnt_next     = SETTLE_M1;
          state_next   = DRIVE;
        end
      end
      DRIVE: begin
        // ALU inputs stay frozen; capture once the settle window has elapsed
        if (cnt_reg != 4'd0) begin
          cnt_next = cnt_reg - 4'd1;
        end else begin
          rsp_out_next   = alu_out;
          rsp_cout_next  = alu_cout;
          rsp_zero_next  = alu_zero;
          rsp_valid_next = 1'b1;
          alu_en_next    = 1'b1;
          state_next     = RESP;
        end
      end
      RESP: begin
        if (rsp_ready) begin
          rsp_valid_next = 1'b0;
          op_count_next  = op_count_reg + 16'd1;
          state_next     = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign req_ready = (state_reg == IDLE);
  assign rsp_valid = rsp_valid_reg;
  assign rsp_out   = rsp_out_reg;
  assign rsp_cout  = rsp_cout_reg;
  assign rsp_zero  = rsp_zero_reg;
  assign alu_a     = alu_a_reg;
  assign alu_b     = alu_b_reg;
  assign alu_md    = alu_md_reg;
  assign alu_cin   = alu_cin_reg;
  assign alu_en    = alu_en_reg;
  assign op_count  = op_count_reg;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Scoreboard bench for alu_op_sequencer: a behavioural ALU sits on the alu_* side,
// directed requests push expected responses, a negedge monitor pops and compares.
module tb_alu_op_sequencer;
  localparam int BW     = 32;
  localparam int SETTLE = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic          req_valid, req_ready;
  logic [BW-1:0] req_a, req_b;
  logic [2:0]    req_md;
  logic          req_cin;
  logic          rsp_valid, rsp_ready;
  logic [BW-1:0] rsp_out;
  logic          rsp_cout, rsp_zero;
  logic [BW-1:0] alu_a, alu_b;
  logic [2:0]    alu_md;
  logic          alu_cin, alu_en;
  logic [BW-1:0] alu_out;
  logic          alu_cout, alu_zero;
  logic [15:0]   op_count;

  typedef struct packed {
    logic [BW-1:0] out;
    logic          cout;
    logic          zero;
  } rsp_t;

  rsp_t        exp_q[$];
  logic [15:0] exp_count = '0;
  int          tests = 0;
  int          failed = 0;

  always #5 clk = ~clk;

  alu_op_sequencer #(.BUS_WIDTH(BW), .SETTLE(SETTLE)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .req_md(req_md), .req_cin(req_cin),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_out(rsp_out), .rsp_cout(rsp_cout), .rsp_zero(rsp_zero),
    .alu_a(alu_a), .alu_b(alu_b), .alu_md(alu_md), .alu_cin(alu_cin), .alu_en(alu_en),
    .alu_out(alu_out), .alu_cout(alu_cout), .alu_zero(alu_zero),
    .op_count(op_count)
  );

  // Behavioural ALU: 0 AND, 1 OR, 2 XOR, 3 ADD with carry, others pass A
  always_comb begin
    logic [BW:0] sum;
    sum = {1'b0, alu_a} + {1'b0, alu_b} + {{BW{1'b0}}, alu_cin};
    case (alu_md)
      3'd0:    {alu_cout, alu_out} = {1'b0, alu_a & alu_b};
      3'd1:    {alu_cout, alu_out} = {1'b0, alu_a | alu_b};
      3'd2:    {alu_cout, alu_out} = {1'b0, alu_a ^ alu_b};
      3'd3:    {alu_cout, alu_out} = sum;
      default: {alu_cout, alu_out} = {1'b0, alu_a};
    endcase
    alu_zero = (alu_out == '0);
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Monitor: a handshake completes at the next edge whenever valid&ready is seen here
  always @(negedge clk) begin
    if (!rst && rsp_valid && rsp_ready) begin
      rsp_t e;
      tests++;
      if (exp_q.size() == 0) begin
        failed++;
        $display("FAIL rsp_unexpected: got out=%0h with no pending request", rsp_out);
      end else begin
        tests--;
        e = exp_q.pop_front();
        chk("rsp_out", 64'(rsp_out), 64'(e.out));
        chk("rsp_cout", 64'(rsp_cout), 64'(e.cout));
        chk("rsp_zero", 64'(rsp_zero), 64'(e.zero));
        $display("[TB] rsp out=%08h cout=%0b zero=%0b", rsp_out, rsp_cout, rsp_zero);
      end
      exp_count = exp_count + 16'd1;
    end
  end

  task automatic accept(input logic [BW-1:0] a, input logic [BW-1:0] b,
                        input logic [2:0] md, input logic cin);
    int n = 0;
    @(negedge clk);
    req_a = a; req_b = b; req_md = md; req_cin = cin; req_valid = 1'b1;
    while (!req_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!req_ready) chk("req_ready_timeout", 64'(req_ready), 64'd1);
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    chk("alu_en_busy", 64'(alu_en), 64'd0);
    chk("alu_a", 64'(alu_a), 64'(a));
    chk("alu_b", 64'(alu_b), 64'(b));
    chk("alu_md_cin", 64'({alu_md, alu_cin}), 64'({md, cin}));
  endtask

  // Issue an op, push its expected response, and check capture latency
  task automatic issue(input logic [BW-1:0] a, input logic [BW-1:0] b,
                       input logic [2:0] md, input logic cin,
                       input logic [BW-1:0] e_out, input logic e_cout, input logic e_zero);
    int lat = 0;
    exp_q.push_back({e_out, e_cout, e_zero});
    accept(a, b, md, cin);
    while (!rsp_valid && lat < 50) begin
      @(posedge clk);
      #1;
      lat++;
      if (!rsp_valid) chk("alu_en_inflight", 64'(alu_en), 64'd0);
    end
    chk("rsp_latency", 64'(lat), 64'(SETTLE));
    chk("alu_en_done", 64'(alu_en), 64'd1);
    $display("[TB] req a=%08h b=%08h md=%0d cin=%0b latency=%0d", a, b, md, cin, lat);
  endtask

  task automatic check_count(input string name);
    repeat (2) @(negedge clk);
    chk(name, 64'(op_count), 64'(exp_count));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("[TB] %0d tests run, %0d failed", tests, failed + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; req_valid = 1'b0; req_a = '0; req_b = '0; req_md = '0; req_cin = 1'b0;
    rsp_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    // Reset state
    @(negedge clk);
    chk("rst_req_ready", 64'(req_ready), 64'd1);
    chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("rst_rsp", 64'({rsp_out, rsp_cout, rsp_zero}), 64'd0);
    chk("rst_alu_ab", 64'({alu_a, alu_b}), 64'd0);
    chk("rst_alu_md_cin", 64'({alu_md, alu_cin}), 64'd0);
    chk("rst_alu_en", 64'(alu_en), 64'd1);
    chk("rst_op_count", 64'(op_count), 64'd0);

    // rsp_ready early has no effect; single AND
    @(posedge clk); #1 rsp_ready = 1'b1;
    issue(32'h0000_00F0, 32'h0000_003C, 3'd0, 1'b0, 32'h0000_0030, 1'b0, 1'b0);
    check_count("count_after_and");

    // Back-pressure on an XOR with zero result
    @(posedge clk); #1 rsp_ready = 1'b0;
    issue(32'h1234_5678, 32'h1234_5678, 3'd2, 1'b0, 32'h0, 1'b0, 1'b1);
    repeat (5) begin
      @(negedge clk);
      chk("bp_rsp_valid", 64'(rsp_valid), 64'd1);
      chk("bp_rsp_out", 64'(rsp_out), 64'd0);
      chk("bp_rsp_zero", 64'(rsp_zero), 64'd1);
      chk("bp_req_ready", 64'(req_ready), 64'd0);
      chk("bp_op_count", 64'(op_count), 64'd1);
    end
    @(posedge clk); #1 rsp_ready = 1'b1;
    check_count("count_after_bp");
    @(negedge clk);
    chk("hold_rsp_zero", 64'(rsp_zero), 64'd1);

    // Carry-out, carry-in and pass-through modes
    issue(32'hFFFF_FFFF, 32'h0000_0001, 3'd3, 1'b0, 32'h0, 1'b1, 1'b1);
    issue(32'h0000_0005, 32'h0000_0007, 3'd3, 1'b1, 32'h0000_000D, 1'b0, 1'b0);
    issue(32'hDEAD_BEEF, 32'h0000_1111, 3'd5, 1'b0, 32'hDEAD_BEEF, 1'b0, 1'b0);
    issue(32'hA5A5_0000, 32'h0000_5A5A, 3'd1, 1'b0, 32'hA5A5_5A5A, 1'b0, 1'b0);
    check_count("count_after_modes");

    // Sweep of logic modes over small operands
    for (int a = 0; a < 10; a++) begin
      for (int b = 0; b < 10; b++) begin
        for (int md = 0; md < 3; md++) begin
          logic [BW-1:0] e;
          e = (md == 0) ? BW'(a & b) : (md == 1) ? BW'(a | b) : BW'(a ^ b);
          issue(BW'(a), BW'(b), 3'(md), 1'b0, e, 1'b0, e == '0);
        end
      end
    end
    check_count("count_after_sweep");

    // Reset while in DRIVE abandons the op
    accept(32'h0000_00FF, 32'h0000_0F0F, 3'd0, 1'b0);
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    exp_count = '0;
    chk("midrst_req_ready", 64'(req_ready), 64'd1);
    chk("midrst_alu_en", 64'(alu_en), 64'd1);
    chk("midrst_op_count", 64'(op_count), 64'd0);
    repeat (4) begin
      @(negedge clk);
      chk("midrst_no_rsp", 64'(rsp_valid), 64'd0);
    end
    issue(32'h0000_00FF, 32'h0000_0F0F, 3'd0, 1'b0, 32'h0000_000F, 1'b0, 1'b0);
    check_count("count_after_midrst");

    // Counter wrap from a preloaded value
    @(negedge clk);
    force dut.op_count_reg = 16'hFFFE;
    @(negedge clk);
    release dut.op_count_reg;
    exp_count = 16'hFFFE;
    chk("wrap_preload", 64'(op_count), 64'hFFFE);
    issue(32'h0000_0003, 32'h0000_0006, 3'd2, 1'b0, 32'h0000_0005, 1'b0, 1'b0);
    check_count("wrap_ffff");
    issue(32'h0000_0003, 32'h0000_0006, 3'd1, 1'b0, 32'h0000_0007, 1'b0, 1'b0);
    check_count("wrap_zero");
    chk("wrap_zero_abs", 64'(op_count), 64'h0000);

    repeat (3) @(negedge clk);
    chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end
endmodule
